// File: rtl/fib_checker.sv
// Fibonacci-sum stream checker: locks onto two seed samples, then predicts and checks each sample.
// Optional FIB_CHECKER_STRICT_START_EN: seeds must be the generator's post-reset values 1 and 2.
module fib_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             locked,
  output logic             mismatch,
  output logic [WIDTH-1:0] expected,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] err_count
);

  // state | meaning
  // HUNT0 | no seed held
  // HUNT1 | one seed held in prev
  // TRACK | prev and last held, checking prev+last
  typedef enum logic [1:0] {HUNT0, HUNT1, TRACK} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nx;
  logic [WIDTH-1:0] prev, prev_nx, last, last_nx, sum;
  logic             armed, consume, mismatch_nx, match_inc, err_inc;

  assign sum      = prev + last;
  assign locked   = (state == TRACK);
  assign expected = locked ? sum : '0;
  // The first edge after reset release only arms the checker; no sample is taken on it.
  assign consume  = armed && in_valid && !clear;

  always_comb begin
    state_nx    = state;
    prev_nx     = prev;
    last_nx     = last;
    mismatch_nx = 1'b0;
    match_inc   = 1'b0;
    err_inc     = 1'b0;
    if (clear) begin
      state_nx = HUNT0;
      prev_nx  = '0;
      last_nx  = '0;
    end else if (consume) begin
      case (state)
        HUNT0: begin
`ifdef FIB_CHECKER_STRICT_START_EN
          if (in_data == WIDTH'(1)) begin
            prev_nx  = in_data;
            state_nx = HUNT1;
          end else begin
            mismatch_nx = 1'b1;
            err_inc     = 1'b1;
          end
`else
          prev_nx  = in_data;
          state_nx = HUNT1;
`endif
        end
        HUNT1: begin
`ifdef FIB_CHECKER_STRICT_START_EN
          if (in_data == WIDTH'(2)) begin
            last_nx  = in_data;
            state_nx = TRACK;
          end else begin
            mismatch_nx = 1'b1;
            err_inc     = 1'b1;
            prev_nx     = '0;
            state_nx    = HUNT0;
          end
`else
          last_nx  = in_data;
          state_nx = TRACK;
`endif
        end
        TRACK: begin
          if (in_data == sum) begin
            prev_nx   = last;
            last_nx   = in_data;
            match_inc = 1'b1;
          end else begin
            mismatch_nx = 1'b1;
            err_inc     = 1'b1;
`ifdef FIB_CHECKER_STRICT_START_EN
            prev_nx  = '0;
            last_nx  = '0;
            state_nx = HUNT0;
`else
            prev_nx  = in_data;
            state_nx = HUNT1;
`endif
          end
        end
        default: begin
          state_nx = HUNT0;
          prev_nx  = '0;
          last_nx  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= HUNT0;
      prev        <= '0;
      last        <= '0;
      armed       <= 1'b0;
      mismatch    <= 1'b0;
      match_count <= '0;
      err_count   <= '0;
    end else begin
      state    <= state_nx;
      prev     <= prev_nx;
      last     <= last_nx;
      armed    <= 1'b1;
      mismatch <= mismatch_nx;
      if (clear) begin
        match_count <= '0;
        err_count   <= '0;
      end else begin
        if (match_inc && match_count != CNT_MAX) match_count <= match_count + CNT_W'(1);
        if (err_inc && err_count != CNT_MAX)     err_count   <= err_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fib_checker.sv
// Bench for fib_checker: vector tables, directed corner sequences and random stimulus vs a queue model.
module tb_fib_checker;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int MODV  = 1 << WIDTH;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             clear;
  logic             locked, mismatch;
  logic [WIDTH-1:0] expected;
  logic [CNT_W-1:0] match_count, err_count;

  fib_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .locked(locked), .mismatch(mismatch), .expected(expected),
    .match_count(match_count), .err_count(err_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: the held seeds as a queue of plain integers.
  int seeds[$];
  int m_match, m_err, m_mis;
  bit m_armed;

  typedef struct {
    bit v; int d; bit c;
    bit l; bit mis; int ex; int mc; int ec;
  } vec_t;
  vec_t vecs[$];

  function automatic bit m_locked();
    return seeds.size() == 2;
  endfunction

  function automatic int m_expected();
    return m_locked() ? (seeds[0] + seeds[1]) % MODV : 0;
  endfunction

  function automatic int sat(int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, wanted %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    seeds.delete();
    m_match = 0; m_err = 0; m_mis = 0; m_armed = 0;
  endtask

  task automatic model_edge(input bit v, input int d, input bit c);
    bit bad;
    int want;
    bad = 0;
    m_mis = 0;
    if (c) begin
      seeds.delete(); m_match = 0; m_err = 0; m_armed = 1;
      return;
    end
    if (!m_armed) begin
      m_armed = 1;
      return;
    end
    if (!v) return;
    if (seeds.size() < 2) begin
`ifdef FIB_CHECKER_STRICT_START_EN
      want = seeds.size() + 1;
      if (d != want) begin bad = 1; seeds.delete(); end
      else seeds.push_back(d);
`else
      want = d;
      seeds.push_back(want);
`endif
    end else if (d == (seeds[0] + seeds[1]) % MODV) begin
      void'(seeds.pop_front());
      seeds.push_back(d);
      m_match = sat(m_match + 1);
    end else begin
      bad = 1;
      seeds.delete();
`ifndef FIB_CHECKER_STRICT_START_EN
      seeds.push_back(d);
`endif
    end
    if (bad) begin
      m_mis = 1;
      m_err = sat(m_err + 1);
    end
  endtask

  task automatic chk_model();
    chk("locked",      int'(locked),      int'(m_locked()));
    chk("mismatch",    int'(mismatch),    m_mis);
    chk("expected",    int'(expected),    m_expected());
    chk("match_count", int'(match_count), m_match);
    chk("err_count",   int'(err_count),   m_err);
  endtask

  task automatic step(input bit v, input int d, input bit c);
    in_valid = v;
    in_data  = WIDTH'(d);
    clear    = c;
    @(posedge clock);
    model_edge(v, d, c);
    #1;
    chk_model();
  endtask

  task automatic add(input bit v, input int d, input bit c,
                     input bit l, input bit mis, input int ex, input int mc, input int ec);
    vec_t e;
    e.v = v; e.d = d; e.c = c; e.l = l; e.mis = mis; e.ex = ex; e.mc = mc; e.ec = ec;
    vecs.push_back(e);
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].d, vecs[i].c);
      chk("vec_locked",   int'(locked),      int'(vecs[i].l));
      chk("vec_mismatch", int'(mismatch),    int'(vecs[i].mis));
      chk("vec_expected", int'(expected),    vecs[i].ex);
      chk("vec_match",    int'(match_count), vecs[i].mc);
      chk("vec_err",      int'(err_count),   vecs[i].ec);
    end
    vecs.delete();
  endtask

  int stream[14] = '{1, 2, 3, 5, 8, 13, 5, 2, 7, 9, 0, 9, 9, 2};
  int hold_exp;
  int d;

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_state", int'(locked) + int'(mismatch) + int'(expected) + int'(match_count) + int'(err_count), 0);
    reset = 1'b1;
    // First edge after release must not consume this valid sample.
    step(1, 7, 0);
    chk("no_consume_after_release", int'(locked), 0);

`ifndef FIB_CHECKER_STRICT_START_EN
    step(0, 0, 1);
    // Back-to-back golden stream, including wrap-around matches.
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 2, 0, 1, 0, 3, 0, 0);
    add(1, 3, 0, 1, 0, 5, 1, 0);
    add(1, 5, 0, 1, 0, 8, 2, 0);
    add(1, 8, 0, 1, 0, 13, 3, 0);
    add(1, 13, 0, 1, 0, 5, 4, 0);
    add(1, 5, 0, 1, 0, 2, 5, 0);
    add(1, 2, 0, 1, 0, 7, 6, 0);
    add(1, 7, 0, 1, 0, 9, 7, 0);
    add(1, 9, 0, 1, 0, 0, 8, 0);
    add(1, 0, 0, 1, 0, 9, 9, 0);
    add(1, 9, 0, 1, 0, 9, 10, 0);
    add(1, 9, 0, 1, 0, 2, 11, 0);
    add(1, 2, 0, 1, 0, 11, 12, 0);
    run_vecs();

    // Resync after a bad sample: 6 rejected, then 6,9 seed, 15 matches.
    add(0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 2, 0, 1, 0, 3, 0, 0);
    add(1, 3, 0, 1, 0, 5, 1, 0);
    add(1, 6, 0, 0, 1, 0, 1, 1);
    add(1, 9, 0, 1, 0, 15, 1, 1);
    add(1, 15, 0, 1, 0, 8, 2, 1);
    run_vecs();
`else
    add(1, 4, 0, 0, 1, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0, 0, 1);
    add(1, 2, 0, 1, 0, 3, 0, 1);
    add(1, 3, 0, 1, 0, 5, 1, 1);
    run_vecs();
`endif

    // Golden stream with idle cycles interleaved; expected must hold while idle.
    step(0, 0, 1);
    foreach (stream[i]) begin
      step(1, stream[i], 0);
      hold_exp = int'(expected);
      step(0, $urandom_range(0, MODV - 1), 0);
      chk("expected_hold_idle", int'(expected), hold_exp);
    end
    chk("idle_match_total", int'(match_count), 12);
    chk("idle_err_total",   int'(err_count), 0);

    // Clear together with a valid sample in TRACK: sample dropped, counters zeroed.
    step(1, 11, 1);
    chk("clear_locked", int'(locked), 0);
    chk("clear_match",  int'(match_count), 0);
    step(1, 1, 0);
    step(1, 2, 0);
    chk("after_clear_relock", int'(expected), 3);

    // Match counter saturation.
    step(0, 0, 1);
    step(1, 1, 0);
    step(1, 2, 0);
    for (int i = 0; i < 260; i++) step(1, m_expected(), 0);
    chk("match_saturated", int'(match_count), CMAX);

    // Error counter saturation.
    step(0, 0, 1);
    for (int i = 0; i < 900; i++) begin
      if (m_locked()) step(1, (m_expected() + 1) % MODV, 0);
      else step(1, seeds.size() + 1, 0);
    end
    chk("err_saturated", int'(err_count), CMAX);
    step(1, 1, 0);
    step(1, 2, 0);
    step(1, 7, 0);
    chk("err_sat_pulse", int'(mismatch), 1);
    chk("err_stays_max", int'(err_count), CMAX);

    // Random traffic with a mid-stream async reset.
    step(0, 0, 1);
    for (int i = 0; i < 500; i++) begin
      if (i == 250) begin
        reset = 1'b0;
        #1;
        model_reset();
        chk("async_reset_locked", int'(locked), 0);
        chk("async_reset_counts", int'(match_count) + int'(err_count), 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
      end
      if (m_locked() && $urandom_range(0, 3) != 0) d = m_expected();
      else if (seeds.size() < 2 && $urandom_range(0, 1) == 1) d = seeds.size() + 1;
      else d = $urandom_range(0, MODV - 1);
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 40) == 0);
    end

    in_valid = 1'b0;
    clear = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fib_checker.md
FIB_CHECKER -- requirements
Module: fib_checker

Interface
REQ-001 Parameter WIDTH, default 4: width of every checked sample; all arithmetic is modulo 2^WIDTH.
REQ-002 Parameter CNT_W, default 8: width of match_count and err_count.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_data carries a sample this cycle.
REQ-006 in_data  input  WIDTH  sample under check, from the Fibonacci-sum output of the companion generator.
REQ-007 clear  input  1  synchronous request to return to HUNT0 and zero both counters.
REQ-008 locked  output  1  high while state is TRACK.
REQ-009 mismatch  output  1  one-cycle pulse on a rejected sample.
REQ-010 expected  output  WIDTH  predicted next sample; valid only while locked=1.
REQ-011 match_count  output  CNT_W  saturating count of accepted samples checked in TRACK.
REQ-012 err_count  output  CNT_W  saturating count of mismatch pulses.

Function
REQ-013 States: HUNT0 (no seed), HUNT1 (one seed held in prev), TRACK (prev and last held).
REQ-014 A sample is consumed only in a cycle with in_valid=1; cycles with in_valid=0 change no state, counter or register.
REQ-015 HUNT0 + valid: prev <= in_data, go to HUNT1.
REQ-016 HUNT1 + valid: last <= in_data, go to TRACK.
REQ-017 In TRACK, expected = (prev + last) mod 2^WIDTH; the carry out is discarded.
REQ-018 TRACK + valid with in_data == expected: prev <= last, last <= in_data, match_count increments, state stays TRACK.
REQ-019 TRACK + valid with in_data != expected: mismatch=1 in the next cycle, err_count increments, prev <= in_data, go to HUNT1 (resync, with the bad sample as the new seed).
REQ-020 mismatch and the output registers update one cycle after the consuming edge; mismatch is registered and never combinational from in_data.
REQ-021 Both counters saturate at 2^CNT_W-1 and never wrap.
REQ-022 A valid sample equal to expected after wrap-around (e.g. 13+8=21 -> 5 at WIDTH=4) is a match.
REQ-023 clear=1 overrides in_valid in the same cycle: state HUNT0, counters 0, mismatch 0, and the sample is discarded.
REQ-024 expected is driven to 0 when locked=0.

Reset
REQ-025 While reset=0, regardless of clock: state HUNT0, prev=0, last=0, locked=0, mismatch=0, expected=0, match_count=0, err_count=0.
REQ-026 Reset asserted mid-stream discards all history; after release, the first valid sample is treated as a HUNT0 seed.
REQ-027 Reset release is sampled on a clock edge; no sample is consumed in the first edge after release.

Configuration
REQ-028 Macro FIB_CHECKER_STRICT_START_EN.
REQ-029 Defined: the HUNT0 seed must equal 1 and the HUNT1 seed must equal 2 (the generator's first two post-reset outputs). A wrong seed pulses mismatch, increments err_count and returns to HUNT0. In this mode REQ-019 goes to HUNT0 instead of HUNT1.
REQ-030 Not defined: any two values seed the checker, per REQ-015/016/019.

Verification
REQ-031 Release reset, then stream 1,2,3,5,8,13,5,2,7,9,0,9,9,2 back to back -> locked after the 2nd sample, 12 matches, err_count=0, mismatch never high.
REQ-032 Same stream with in_valid low on alternate cycles -> identical final counts; expected holds across idle cycles.
REQ-033 Stream 1,2,3,6,9,15 -> one mismatch pulse on the 6; resync with prev=6, last=9; 15 is a match; final err_count=1, match_count=2.
REQ-034 Assert clear in a cycle with in_valid=1 in TRACK -> locked=0, both counters 0, and that sample is ignored.
REQ-035 Force err_count to 255 with CNT_W=8, inject a further error -> err_count stays 255.
REQ-036 FIB_CHECKER_STRICT_START_EN defined, stream 4,2,... -> mismatch on the 4, state stays HUNT0; then 1,2,3 -> locked, match_count=1.
